// File: rtl/cache_line_axi_master_if.sv
// Bundle of the cache-side line request port and the AXI3 master channels.
// The master modport is the burst engine's view; slave is the cache/crossbar side.
interface cache_line_axi_master_if #(
    parameter int LINE_WORDS = 8
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wr;
    logic [31:0]                req_addr;
    logic [LINE_WORDS*32-1:0]   req_wline;
    logic [LINE_WORDS*32-1:0]   rline;
    logic                       resp_valid;
    logic                       resp_err;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        input  req_valid, req_wr, req_addr, req_wline,
        output req_ready, rline, resp_valid, resp_err,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wline,
        input  req_ready, rline, resp_valid, resp_err,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cache_line_axi_master.sv
// Single-outstanding AXI3 master: one cache-line refill or writeback per request,
// issued as a fixed-length INCR burst of LINE_WORDS 32-bit beats.
module cache_line_axi_master #(
    parameter logic [3:0] ID         = 4'd0,
    parameter int         LINE_WORDS = 8
) (
    input logic                     clk,
    input logic                     rstn,
    cache_line_axi_master_if.master bus
);
    localparam int               LINE_BITS = LINE_WORDS * 32;
    localparam int               OFF_W     = $clog2(LINE_WORDS * 4);
    localparam int               CNT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LINE_WORDS - 1);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [3:0]       BURST_LEN = 4'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5,
        S_DONE = 3'd6
    } state_e;

    state_e                 state_q;
    logic [31:0]            addr_q;
    logic [LINE_BITS-1:0]   wline_q;
    logic [LINE_BITS-1:0]   rline_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   err_q;
    logic                   req_ready_q;
    logic                   arvalid_q;
    logic                   rready_q;
    logic                   awvalid_q;
    logic                   wvalid_q;
    logic                   wlast_q;
    logic [31:0]            wdata_q;
    logic                   bready_q;
    logic                   resp_valid_q;
    logic                   resp_err_q;
    logic                   unused_s;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [CNT_W-1:0]     idx);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            w = (CNT_W'(i) == idx) ? line[i*32 +: 32] : w;
        end
        return w;
    endfunction

    function automatic logic [LINE_BITS-1:0] line_put(input logic [LINE_BITS-1:0] line,
                                                      input logic [CNT_W-1:0]     idx,
                                                      input logic [31:0]          data);
        logic [LINE_BITS-1:0] l;
        l = line;
        for (int i = 0; i < LINE_WORDS; i++) begin
            l[i*32 +: 32] = (CNT_W'(i) == idx) ? data : line[i*32 +: 32];
        end
        return l;
    endfunction

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Drop response LSBs: only the error class bit matters here.
    assign unused_s = ^{bus.rresp[0], bus.bresp[0]};

    // Single-process FSM: every bus-facing control is a register updated here
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            wline_q      <= {LINE_BITS{1'b0}};
            rline_q      <= {LINE_BITS{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            wdata_q      <= 32'd0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        addr_q      <= bus.req_addr & ADDR_MASK;
                        wline_q     <= bus.req_wline;
                        cnt_q       <= {CNT_W{1'b0}};
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (bus.req_wr) begin
                            awvalid_q <= 1'b1;
                            state_q   <= S_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (bus.rvalid && (bus.rid == ID)) begin
                        rline_q <= line_put(rline_q, cnt_q, bus.rdata);
                        cnt_q   <= cnt_d;
                        err_q   <= err_q | bus.rresp[1];
                        // rlast ahead of the final word marks a short burst
                        if (bus.rlast || (cnt_q == LAST_CNT)) begin
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= err_q | bus.rresp[1] | (cnt_q != LAST_CNT);
                            state_q      <= S_DONE;
                        end
                    end
                end
                S_AW: begin
                    if (bus.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= line_word(wline_q, {CNT_W{1'b0}});
                        wlast_q   <= (LAST_CNT == {CNT_W{1'b0}});
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (bus.wready) begin
                        cnt_q <= cnt_d;
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_B;
                        end else begin
                            wdata_q <= line_word(wline_q, cnt_d);
                            wlast_q <= (cnt_d == LAST_CNT);
                        end
                    end
                end
                S_B: begin
                    if (bus.bvalid && (bus.bid == ID)) begin
                        bready_q     <= 1'b0;
                        err_q        <= err_q | bus.bresp[1];
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q | bus.bresp[1];
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                    awvalid_q    <= 1'b0;
                    wvalid_q     <= 1'b0;
                    wlast_q      <= 1'b0;
                    bready_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rline      = rline_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;

    assign bus.arid    = ID;
    assign bus.araddr  = addr_q;
    assign bus.arlen   = BURST_LEN;
    assign bus.arsize  = 3'b010;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign bus.awid    = ID;
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = BURST_LEN;
    assign bus.awsize  = 3'b010;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'b0000;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = awvalid_q;

    assign bus.wid    = ID;
    assign bus.wdata  = wdata_q;
    assign bus.wstrb  = 4'hF;
    assign bus.wlast  = wlast_q;
    assign bus.wvalid = wvalid_q;
    assign bus.bready = bready_q;
endmodule

// File: doc/cache_line_axi_master.md
Name: cache_line_axi_master

Overview:
Single-outstanding AXI3 master that turns whole-cache-line refill and writeback requests into fixed-length INCR bursts. It sits between a cache controller and one slave port of the 2x1 AXI crossbar, one instance per cache, and drives that crossbar port directly. It serves as the burst-capable refill and writeback path for the I- and D-caches.

Parameters:
ID, 4'd0, AXI ID driven on arid/awid/wid; read beats are accepted only when rid==ID.
LINE_WORDS, 8, words per cache line, legal range 1..16; arlen=awlen=LINE_WORDS-1.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
req_valid  in  1  line request valid
req_ready  out  1  block idle, request accepted when req_valid&&req_ready
req_wr  in  1  1=writeback, 0=refill
req_addr  in  32  line address; low log2(LINE_WORDS*4) bits ignored (forced 0)
req_wline  in  LINE_WORDS*32  writeback line; word0 in bits [31:0]
rline  out  LINE_WORDS*32  refill line, word i at [32i+31:32i]; valid when resp_valid
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; 1 = SLVERR/DECERR seen or short burst
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/4/3/2/2/4/3  AR channel
arvalid out 1; arready in 1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready out 1
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  4/32/4/3/2/2/4/3  AW channel
awvalid out 1; awready in 1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready in 1
bid/bresp/bvalid  in  4/2/1; bready out 1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset values:
  - state=IDLE, req_ready=1.
  - All valid/ready outputs 0 (arvalid, awvalid, wvalid, rready, bready).
  - resp_valid=0, resp_err=0, rline=0, beat counter=0.
- Constant fields:
  - arsize=awsize=3'b010, arburst=awburst=2'b01 (INCR).
  - lock, cache and prot fields = 0; wstrb=4'hF.
  - arid=awid=wid=ID.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE:
  - req_ready=1.
  - On a handshake, latch the aligned address, req_wr and req_wline; clear the counter and error flag.
  - Go to AW if req_wr=1, else AR.
  - req_ready is 0 in every state except IDLE.
- AR:
  - arvalid=1 with araddr held stable until arready.
  - Then go to R, arvalid=0 in the next cycle.
- R:
  - rready=1.
  - Beat accepted on rvalid&&rid==ID: write rdata into word[cnt], cnt++, OR rresp[1] into err.
  - The beat with rlast=1, or the beat where cnt==LINE_WORDS-1, ends the burst and goes to DONE.
  - rlast arriving before cnt==LINE_WORDS-1: err=1, unfilled words keep their old value.
- AW:
  - awvalid=1 until awready, then go to W.
- W:
  - wvalid=1, wdata=word[cnt] of the latched line, wlast=(cnt==LINE_WORDS-1).
  - cnt++ on each wready; the last beat goes to B.
  - wvalid is never dropped mid-burst.
- B:
  - bready=1; on bvalid&&bid==ID, err|=bresp[1], go to DONE.
- DONE:
  - resp_valid=1 and resp_err=err for exactly one cycle, then IDLE.
  - A new request can be accepted in the cycle after DONE.
- Latency (zero-wait slave):
  - Read: handshake in cycle 0, arvalid in cycle 1, first rready beat in cycle 2, resp_valid in cycle LINE_WORDS+2.
  - Write: resp_valid in cycle LINE_WORDS+3.
- rline is registered and holds its value until the next refill starts writing it; it is not cleared between requests.
- Responses with a foreign rid/bid are not accepted. rready/bready stay asserted for them; the crossbar routes by port, so these never occur in practice.
- Reset mid-burst: all valids drop immediately (async), no resp_valid pulse, FSM returns to IDLE.

Test Plan:
1. Refill, req_addr=0x1FC0_0014, LINE_WORDS=8, zero-wait slave returning 0x100..0x107 -> araddr=0x1FC0_0000, arlen=7, arsize=2, arburst=1; rline word i = 0x100+i; resp_valid pulse in cycle 10; resp_err=0.
2. Writeback, addr 0x0000_1000, line words 0xA0..0xA7, wready toggling every other cycle -> awlen=7; wdata sequence 0xA0..0xA7 with wlast only on 0xA7; wvalid never drops mid-burst; resp_valid after bvalid; resp_err=0.
3. arready delayed 5 cycles with req_valid held high -> araddr stable throughout, req_ready=0, exactly one AR handshake, no second request taken.
4. rresp=2'b10 on beat 3, then bresp=2'b11 on a following write -> resp_err=1 for both, with the full 8 beats still consumed on the read.
5. Premature rlast on beat 5 -> resp_valid with resp_err=1; words 0..5 updated, words 6..7 unchanged.
6. rstn pulled low during W beat 4 -> wvalid=0 asynchronously; after release req_ready=1 and no resp_valid; a new refill then completes normally.
